// File: rtl/pc_sequencer.sv
// Next-address controller for the KGP-miniRISC PC register: sequences FETCH/EXEC,
// resolves halt/return/branch/call and keeps a small circular return-address stack.
module pc_sequencer #(
  parameter int unsigned ADDR_MAX  = 1000,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] curr_pc,
  input  logic        exec_done,
  input  logic        halt,
  input  logic        is_ret,
  input  logic        is_call,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] next_pc,
  output logic        fetch_valid,
  output logic        halted,
  output logic        addr_fault,
  output logic        ras_overflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] AMAX = 32'(ADDR_MAX);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;

  state_t        state_q, state_d;
  logic [31:0]   ras_q [RAS_DEPTH];
  logic [PW-1:0] wptr_q;
  logic [CW-1:0] cnt_q;

  logic [31:0]   pc_inc, ras_top, cand;
  logic [PW-1:0] top_idx;
  logic          push, pop, fault;

  assign pc_inc  = curr_pc + 32'd1;
  assign top_idx = wptr_q - 1'b1;
  assign ras_top = ras_q[top_idx];

  // The PC register loads next_pc every edge, so "hold" means echoing curr_pc.
  always_comb begin
    next_pc = curr_pc;
    state_d = state_q;
    cand    = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    fault   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        next_pc = pc_inc;
        state_d = FETCH;
      end
      FETCH: state_d = EXEC;
      EXEC: if (exec_done) begin
        if (halt) begin
          state_d = HALTED;
        end else if (is_ret && cnt_q == '0) begin
          fault   = 1'b1;
          next_pc = AMAX;
          state_d = HALTED;
        end else begin
          if (is_ret) begin
            cand = ras_top;
            pop  = 1'b1;
          end else if (branch_taken) begin
            cand = branch_target;
            push = is_call;
          end
          // An out-of-range destination parks the PC and discards any stack update.
          if (cand > AMAX) begin
            fault   = 1'b1;
            push    = 1'b0;
            pop     = 1'b0;
            next_pc = AMAX;
            state_d = HALTED;
          end else begin
            next_pc = cand;
            state_d = FETCH;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      cnt_q        <= '0;
      fetch_valid  <= 1'b0;
      halted       <= 1'b0;
      addr_fault   <= 1'b0;
      ras_overflow <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      fetch_valid <= (state_d == FETCH);
      halted      <= (state_d == HALTED);
      if (fault) addr_fault <= 1'b1;
      if (push) begin
        // When full the write pointer lands on the oldest entry and overwrites it.
        ras_q[wptr_q] <= pc_inc;
        wptr_q        <= wptr_q + 1'b1;
        if (cnt_q == FULL) ras_overflow <= 1'b1;
        else               cnt_q        <= cnt_q + 1'b1;
      end else if (pop) begin
        wptr_q <= wptr_q - 1'b1;
        cnt_q  <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a PC-register model and an expected-output queue.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, exec_done, halt, is_ret, is_call, branch_taken;
  logic [31:0] curr_pc, branch_target, next_pc;
  logic        fetch_valid, halted, addr_fault, ras_overflow;

  typedef struct {
    string       tag;
    logic [31:0] nxt;
    logic        fv;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_pass = 0, n_fail = 0;

  pc_sequencer #(.ADDR_MAX(1000), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .curr_pc(curr_pc), .exec_done(exec_done),
    .halt(halt), .is_ret(is_ret), .is_call(is_call), .branch_taken(branch_taken),
    .branch_target(branch_target), .next_pc(next_pc), .fetch_valid(fetch_valid),
    .halted(halted), .addr_fault(addr_fault), .ras_overflow(ras_overflow)
  );

  always #5 clk = ~clk;

  // PC register: loads next_pc every edge, 0xFFFFFFFF in reset.
  always_ff @(posedge clk or posedge rst)
    if (rst) curr_pc <= 32'hFFFF_FFFF;
    else     curr_pc <= next_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] nxt, input logic fv);
    q.push_back('{tag, nxt, fv});
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".next_pc"}, next_pc, e.nxt);
      chk({e.tag, ".fetch_valid"}, {31'b0, fetch_valid}, {31'b0, e.fv});
    end
  endtask

  task automatic clear_in();
    start = 0; exec_done = 0; halt = 0; is_ret = 0; is_call = 0;
    branch_taken = 0; branch_target = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    clear_in();
  endtask

  task automatic flags(input string tag, input logic h, input logic af, input logic ov);
    #1;
    chk({tag, ".halted"},       {31'b0, halted},       {31'b0, h});
    chk({tag, ".addr_fault"},   {31'b0, addr_fault},   {31'b0, af});
    chk({tag, ".ras_overflow"}, {31'b0, ras_overflow}, {31'b0, ov});
  endtask

  task automatic do_reset(input string tag);
    clear_in();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    expect_out({tag, ".rst"}, 32'hFFFF_FFFF, 1'b0);
    drain();
    flags({tag, ".rst"}, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic boot();
    expect_out("idle", 32'hFFFF_FFFF, 1'b0);
    drain();
    start = 1;
    expect_out("start", 32'h0, 1'b0);
    drain();
    tick();
  endtask

  // Starts in FETCH at pc; ends in the state following the EXEC cycle.
  task automatic instr(input logic [31:0] pc, input logic h, input logic r, input logic c,
                       input logic b, input logic [31:0] tgt, input logic [31:0] exp_next);
    expect_out($sformatf("fetch@%0d", pc), pc, 1'b1);
    drain();
    tick();
    exec_done = 1; halt = h; is_ret = r; is_call = c; branch_taken = b; branch_target = tgt;
    expect_out($sformatf("exec@%0d", pc), exp_next, 1'b0);
    drain();
    tick();
  endtask

  initial begin
    clear_in();
    rst = 1;
    #2;
    expect_out("reset", 32'hFFFF_FFFF, 1'b0);
    drain();
    flags("reset", 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 rst = 0;

    // Sequential flow, call to 40 and return to 6.
    boot();
    for (int i = 0; i < 5; i++) instr(i, 0, 0, 0, 0, 0, i + 1);
    instr(5, 0, 0, 1, 1, 40, 40);
    instr(40, 0, 0, 0, 0, 0, 41);
    instr(41, 0, 1, 0, 0, 0, 6);
    instr(6, 0, 0, 0, 0, 0, 7);

    // Five nested calls overflow a 4-deep stack; returns come back LIFO.
    instr(7,   0, 0, 1, 1, 100, 100);
    instr(100, 0, 0, 1, 1, 200, 200);
    instr(200, 0, 0, 1, 1, 300, 300);
    instr(300, 0, 0, 1, 1, 400, 400);
    flags("call4", 1'b0, 1'b0, 1'b0);
    instr(400, 0, 0, 1, 1, 500, 500);
    flags("call5", 1'b0, 1'b0, 1'b1);
    instr(500, 0, 1, 0, 0, 0, 401);
    instr(401, 0, 1, 0, 0, 0, 301);
    instr(301, 0, 1, 0, 0, 0, 201);
    instr(201, 0, 1, 0, 0, 0, 101);
    expect_out("fetch@101", 101, 1'b1);
    drain();
    tick();
    exec_done = 1; is_ret = 1;
    expect_out("ret_underflow", 32'd1000, 1'b0);
    drain();
    tick();
    flags("underflow", 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      start = 1;
      expect_out("halted_hold", 32'd1000, 1'b0);
      drain();
      tick();
    end

    // Out-of-range branch target.
    do_reset("r1");
    boot();
    for (int i = 0; i < 7; i++) instr(i, 0, 0, 0, 0, 0, i + 1);
    instr(7, 0, 0, 0, 1, 1001, 1000);
    flags("range", 1'b1, 1'b1, 1'b0);
    start = 1;
    expect_out("range_hold", 32'd1000, 1'b0);
    drain();
    tick();
    chk("range_pc", curr_pc, 32'd1000);

    // Halt takes priority over return and branch.
    do_reset("r2");
    boot();
    instr(0, 0, 0, 1, 1, 50, 50);
    instr(50, 1, 1, 0, 1, 9, 50);
    flags("halt_prio", 1'b1, 1'b0, 1'b0);
    expect_out("halt_hold", 32'd50, 1'b0);
    drain();

    // Stall in EXEC, then reset on the fifth stalled cycle.
    do_reset("r3");
    boot();
    expect_out("stall_fetch", 32'h0, 1'b1);
    drain();
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        exec_done = 1;
        rst = 1;
      end
      if (i < 4) expect_out($sformatf("stall%0d", i), 32'h0, 1'b0);
      else       expect_out($sformatf("stall_rst%0d", i), 32'hFFFF_FFFF, 1'b0);
      drain();
      if (i >= 4) flags("stall_rst", 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      exec_done = 0;
    end
    rst = 0;
    expect_out("post_rst_idle", 32'hFFFF_FFFF, 1'b0);
    drain();
    tick();
    expect_out("post_rst_idle2", 32'hFFFF_FFFF, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
